// File: rtl/audio_mixer.sv
`default_nettype none
// ============================================================================
// Module   : audio_mixer
// Purpose  : Time-multiplexed audio mixer feeding the delta-sigma DAC input.
//            On each accepted strobe all channel samples and volumes are
//            snapshotted, then one channel per clock is multiply-accumulated.
//            The sum is scaled by 1/16, saturated and presented on d.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   strobe   in   sample-rate pulse requesting one mix
//   ch       in   CHANNELS packed unsigned samples, MSBI+1 bits each
//   vol      in   CHANNELS packed 4-bit volumes (0 silent .. 15 full)
//   mute     in   forces the mixed result to zero (sampled at the OUT edge)
//   d        out  registered mixed sample to the DAC
//   valid    out  one-cycle pulse, d was updated at the preceding edge
//   busy     out  high while a mix is in progress
//   overrun  out  one-cycle pulse, a strobe arrived while busy and was dropped
// ============================================================================
module audio_mixer #(
  parameter int CHANNELS = 4,
  parameter int MSBI     = 7
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         strobe,
  input  logic [CHANNELS*(MSBI+1)-1:0] ch,
  input  logic [CHANNELS*4-1:0]        vol,
  input  logic                         mute,
  output logic [MSBI:0]                d,
  output logic                         valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int c_sample_w = MSBI + 1;
  localparam int c_prod_w   = c_sample_w + 4;
  localparam int c_idx_w    = $clog2(CHANNELS);
  // Wide enough for CHANNELS full-scale products, so the sum never wraps.
  localparam int c_acc_w    = MSBI + 5 + $clog2(CHANNELS);

  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(CHANNELS - 1);
  localparam logic [MSBI:0]      c_max      = '1;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_acc  = 2'd1;
  localparam logic [1:0] c_out  = 2'd2;

  logic [1:0]                   r_state;
  logic [1:0]                   w_next_state;
  logic [CHANNELS*c_sample_w-1:0] r_snap_ch;
  logic [CHANNELS*4-1:0]        r_snap_vol;
  logic [c_idx_w-1:0]           r_idx;
  logic [c_acc_w-1:0]           r_acc;

  logic                         w_accept;
  logic                         w_acc_en;
  logic                         w_out_en;
  logic [c_sample_w-1:0]        w_sel_ch;
  logic [3:0]                   w_sel_vol;
  logic [c_prod_w-1:0]          w_product;
  logic [c_acc_w-1:0]           w_scaled;
  logic [MSBI:0]                w_sat;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (strobe) w_next_state = c_acc;
      c_acc:   if (r_idx == c_last_idx) w_next_state = c_out;
      c_out:   w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // State decode; busy is a pure decode of the state register, so it has
  // no path from any input.
  always_comb begin
    w_accept = 1'b0;
    w_acc_en = 1'b0;
    w_out_en = 1'b0;
    busy     = 1'b0;
    case (r_state)
      c_idle: w_accept = strobe;
      c_acc: begin
        w_acc_en = 1'b1;
        busy     = 1'b1;
      end
      c_out: begin
        w_out_en = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        w_accept = 1'b0;
      end
    endcase
  end

  // One channel per clock from the snapshot, never from the live inputs.
  assign w_sel_ch  = r_snap_ch[r_idx*c_sample_w +: c_sample_w];
  assign w_sel_vol = r_snap_vol[r_idx*4 +: 4];
  assign w_product = c_prod_w'(w_sel_ch) * c_prod_w'(w_sel_vol);

  // Volume 15 is "full", so dividing by 16 keeps one channel just below
  // full scale; several loud channels clip at the top code.
  assign w_scaled = r_acc >> 4;
  assign w_sat    = (w_scaled > c_acc_w'(c_max)) ? c_max : w_scaled[MSBI:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_snap_ch  <= '0;
      r_snap_vol <= '0;
      r_idx      <= '0;
      r_acc      <= '0;
      d          <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      valid   <= w_out_en;
      overrun <= strobe & busy;
      if (w_accept) begin
        r_snap_ch  <= ch;
        r_snap_vol <= vol;
        r_idx      <= '0;
        r_acc      <= '0;
      end
      if (w_acc_en) begin
        r_acc <= r_acc + c_acc_w'(w_product);
        if (r_idx != c_last_idx) begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (w_out_en) begin
        d <= mute ? '0 : w_sat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_mixer
// Purpose  : Self-checking bench for audio_mixer. A transaction-level model
//            predicts d/valid/busy/overrun every cycle; directed scenarios
//            pin the model with hand-computed values, then a random phase
//            exercises strobes, mute and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_mixer;

  localparam int CH = 4;
  localparam int W  = 8;

  logic            clock  = 1'b0;
  logic            reset  = 1'b1;
  logic            strobe = 1'b0;
  logic            mute   = 1'b0;
  logic [CH*W-1:0] ch     = '0;
  logic [CH*4-1:0] vol    = '0;
  logic [W-1:0]    d;
  logic            valid;
  logic            busy;
  logic            overrun;

  int checks = 0;
  int errors = 0;

  audio_mixer #(.CHANNELS(CH), .MSBI(W-1)) dut (
    .clock   (clock),
    .reset   (reset),
    .strobe  (strobe),
    .ch      (ch),
    .vol     (vol),
    .mute    (mute),
    .d       (d),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clock = ~clock;

  // Expected mix result straight from the arithmetic definition.
  function automatic int exp_mix(input logic [CH*W-1:0] c, input logic [CH*4-1:0] v);
    int sum;
    sum = 0;
    for (int i = 0; i < CH; i++) begin
      sum += int'(c[i*W +: W]) * int'(v[i*4 +: 4]);
    end
    sum = sum / 16;
    if (sum > 255) sum = 255;
    return sum;
  endfunction

  // Timing model: an accepted strobe makes the block busy for CH+1 cycles,
  // and the result lands on the last of those edges.
  int m_cnt   = 0;
  int m_res   = 0;
  int m_d     = 0;
  bit m_valid = 1'b0;
  bit m_over  = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_cnt   <= 0;
      m_res   <= 0;
      m_d     <= 0;
      m_valid <= 1'b0;
      m_over  <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      m_over  <= strobe && (m_cnt != 0);
      if (m_cnt == 0) begin
        if (strobe) begin
          m_res <= exp_mix(ch, vol);
          m_cnt <= CH + 1;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_d     <= mute ? 0 : m_res;
          m_valid <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("d", int'(d), m_d);
    chk("valid", int'(valid), int'(m_valid));
    chk("busy", int'(busy), int'(m_cnt != 0));
    chk("overrun", int'(overrun), int'(m_over));
  endtask

  // Advance one clock and check every output against the model.
  task automatic step();
    @(posedge clock);
    #1;
    compare_model();
  endtask

  task automatic set_all(input int cval, input int vval);
    for (int i = 0; i < CH; i++) begin
      ch[i*W +: W]  = cval[W-1:0];
      vol[i*4 +: 4] = vval[3:0];
    end
  endtask

  // One isolated mix with the current ch/vol/mute; checks result, latency,
  // busy length and single-cycle valid against literal expectations.
  task automatic run_mix(input string name, input int exp_d);
    int busy_cnt;
    int valid_at;
    int valid_cnt;
    int dval;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    busy_cnt  = int'(busy);
    valid_at  = -1;
    valid_cnt = 0;
    dval      = -1;
    for (int k = 1; k <= CH + 2; k++) begin
      step();
      if (busy) busy_cnt++;
      if (valid) begin
        valid_cnt++;
        if (valid_at < 0) valid_at = k;
      end
      if (k == CH + 1) dval = int'(d);
    end
    chk({name, "_d"}, dval, exp_d);
    chk({name, "_latency"}, valid_at, CH + 1);
    chk({name, "_valid_len"}, valid_cnt, 1);
    chk({name, "_busy_len"}, busy_cnt, CH + 1);
  endtask

  initial begin
    int ov_cnt;
    int vcnt;
    int mode;

    // Asynchronous reset without any clock edge.
    #1 reset = 1'b0;
    #2;
    chk("rst_d", int'(d), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    #19 reset = 1'b1;
    step();

    // Single channel: 255*15 = 3825, >>4 = 239.
    set_all(0, 0);
    ch[0 +: W] = 8'd255;
    vol[0 +: 4] = 4'd15;
    run_mix("single", 239);

    // Saturation and a mid-scale mix.
    set_all(255, 15);
    run_mix("sat", 255);
    set_all(16, 8);
    run_mix("mid", 32);

    // Snapshot isolation and dropped strobes.
    set_all(0, 0);
    ch[0 +: W] = 8'd100;
    vol[0 +: 4] = 4'd15;
    strobe = 1'b1;
    step();
    ch[0 +: W] = 8'd0;
    ov_cnt = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (overrun) ov_cnt++;
    end
    strobe = 1'b0;
    for (int k = 4; k <= 5; k++) begin
      step();
      if (overrun) ov_cnt++;
    end
    chk("snap_valid", int'(valid), 1);
    chk("snap_d", int'(d), 93);
    chk("overrun_pulses", ov_cnt, 3);
    // Strobe in the valid cycle is accepted.
    ch[0 +: W] = 8'd200;
    strobe = 1'b1;
    step();
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_no_overrun", int'(overrun), 0);
    strobe = 1'b0;
    for (int k = 1; k <= CH + 1; k++) step();
    chk("b2b_valid", int'(valid), 1);
    chk("b2b_d", int'(d), 187);

    // Mute and zero volume.
    set_all(255, 15);
    mute = 1'b1;
    run_mix("mute", 0);
    mute = 1'b0;
    set_all(255, 0);
    ch[0 +: W] = 8'd77;
    vol[0 +: 4] = 4'd15;
    run_mix("prep", 72);
    set_all(255, 0);
    run_mix("zero_vol", 0);

    // Reset in the middle of a mix, with d non-zero beforehand.
    set_all(0, 0);
    ch[0 +: W] = 8'd255;
    vol[0 +: 4] = 4'd15;
    run_mix("prerst", 239);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    step();
    step();
    #2 reset = 1'b0;
    #1;
    chk("midrst_d", int'(d), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_overrun", int'(overrun), 0);
    step();
    #2 reset = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (valid) vcnt++;
    end
    chk("midrst_no_valid", vcnt, 0);
    chk("midrst_d_hold", int'(d), 0);
    run_mix("after_rst", 239);

    // Random traffic checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      mode = int'($urandom_range(0, 3));
      if (mode == 0) begin
        set_all(255, 15);
      end else begin
        ch  = {$urandom, $urandom};
        vol = 16'($urandom);
      end
      strobe = ($urandom_range(0, 2) == 0);
      mute   = ($urandom_range(0, 5) == 0);
      step();
    end
    strobe = 1'b0;
    mute   = 1'b0;
    for (int k = 0; k < CH + 3; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
